// File: rtl/kpu_mem_pkg.sv
// rtl/kpu_mem_pkg.sv - memop codes, controller state enum and byte-lane helper shared with the core
package kpu_mem_pkg;

    localparam logic [31:0] OP_IDLE    = 32'd0;
    localparam logic [31:0] OP_RD_WORD = 32'd1;
    localparam logic [31:0] OP_WR_WORD = 32'd2;
    localparam logic [31:0] OP_RD_BYTE = 32'd3;
    localparam logic [31:0] OP_WR_BYTE = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_REARM = 2'd3
    } mem_state_t;

    // Little-endian: lane 0 is bits 7:0.
    function automatic logic [31:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [31:0] r;
        case (lane)
            2'd0:    r = {24'd0, word[7:0]};
            2'd1:    r = {24'd0, word[15:8]};
            2'd2:    r = {24'd0, word[23:16]};
            default: r = {24'd0, word[31:24]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM, DEPTH x 32 bits with per-byte write enables
module mem_array #(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - core memory request controller: latency FSM, address decode, lane select, error logic
module mem_ctrl
    import kpu_mem_pkg::*;
#(
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memop,
    input  logic [31:0] memaddress,
    input  logic [31:0] memoutdata,
    output logic [31:0] memindata,
    output logic        memready,
    output logic        memerror
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    mem_state_t  state;
    logic [3:0]  cnt;
    logic [31:0] op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] off;
    logic        is_word, is_read, is_write, err;
    logic [AW-1:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_q;
    logic        ram_we;
    logic [31:0] rd_value;

    assign off      = addr_q - BASE;
    assign is_word  = (op_q == OP_RD_WORD) || (op_q == OP_WR_WORD);
    assign is_read  = (op_q == OP_RD_WORD) || (op_q == OP_RD_BYTE);
    assign is_write = (op_q == OP_WR_WORD) || (op_q == OP_WR_BYTE);
    assign err      = (op_q > OP_WR_BYTE) || (off >= SPAN) || (is_word && (addr_q[1:0] != 2'b00));

    // In IDLE the RAM is addressed from the live request so the read is in
    // flight from the accept edge onward; this keeps LATENCY=1 correct.
    assign ram_addr  = (state == ST_IDLE) ? AW'((memaddress - BASE) >> 2) : AW'(off >> 2);
    assign ram_be    = (op_q == OP_WR_BYTE) ? (4'b0001 << addr_q[1:0]) : 4'b1111;
    assign ram_wdata = (op_q == OP_WR_BYTE) ? {4{wdata_q[7:0]}} : wdata_q;
    assign ram_we    = (state == ST_DONE) && !rst && !err && is_write;
    assign rd_value  = (op_q == OP_RD_BYTE) ? byte_lane(ram_q, addr_q[1:0]) : ram_q;

    mem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            memready  <= 1'b0;
            memerror  <= 1'b0;
            memindata <= 32'd0;
            op_q      <= OP_IDLE;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            memready <= 1'b0;
            memerror <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (memop != OP_IDLE) begin
                        op_q    <= memop;
                        addr_q  <= memaddress;
                        wdata_q <= memoutdata;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= ST_DONE;
                        memready <= 1'b1;
                        memerror <= err;
                        if (!err && is_read) begin
                            memindata <= rd_value;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_REARM;
                end
                default: begin
                    if (memop == OP_IDLE) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a word-array reference model
module tb_mem_ctrl;

    localparam int          DEPTH   = 4096;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h00400000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] memop = 32'd0;
    logic [31:0] memaddress = 32'd0;
    logic [31:0] memoutdata = 32'd0;
    logic [31:0] memindata;
    logic        memready;
    logic        memerror;

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd = 32'd0;

    mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .memop      (memop),
        .memaddress (memaddress),
        .memoutdata (memoutdata),
        .memindata  (memindata),
        .memready   (memready),
        .memerror   (memerror)
    );

    always #5 clk = ~clk;

    // Reference: apply one request to the word array, return expected error and read-back register.
    task automatic model(input logic [31:0] op, input logic [31:0] addr, input logic [31:0] wd, output bit err);
        longint off;
        int idx, lane;
        logic [31:0] w;
        off  = longint'(addr) - longint'(BASE);
        err  = (op == 0) || (op > 4) || (off < 0) || (off >= 4 * DEPTH) || ((op == 1 || op == 2) && (addr % 4 != 0));
        idx  = int'(off / 4);
        lane = int'(addr % 4);
        if (!err) begin
            case (op)
                1: exp_rd = ref_mem[idx];
                2: ref_mem[idx] = wd;
                3: exp_rd = (ref_mem[idx] >> (8 * lane)) & 32'hFF;
                default: begin
                    w = ref_mem[idx];
                    w[8*lane +: 8] = wd[7:0];
                    ref_mem[idx] = w;
                end
            endcase
        end
    endtask

    // Drive one request starting at a negedge; report latency, outputs at memready and pulse width.
    task automatic do_op(input logic [31:0] op, input logic [31:0] addr, input logic [31:0] wd, input bit scramble,
                         output int lat, output bit err, output logic [31:0] rd, output int width);
        memop = op;
        memaddress = addr;
        memoutdata = wd;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (memready) begin
                lat = n;
                break;
            end
            if (scramble) begin
                memaddress = $urandom;
                memoutdata = $urandom;
            end
        end
        err = memerror;
        rd = memindata;
        memop = 32'd0;
        @(negedge clk);
        width = memready ? 2 : 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_rd = 32'd0;
        checks++;
        if (memready !== 1'b0) begin failures++; $display("FAIL reset_memready got=%b exp=0", memready); end
        checks++;
        if (memerror !== 1'b0) begin failures++; $display("FAIL reset_memerror got=%b exp=0", memerror); end
        checks++;
        if (memindata !== 32'd0) begin failures++; $display("FAIL reset_memindata got=%h exp=0", memindata); end
    endtask

    task automatic test_init_words();
        int lat, width;
        bit err, eerr;
        logic [31:0] rd, wd;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model(32'd2, BASE + 32'(4 * i), wd, eerr);
            do_op(32'd2, BASE + 32'(4 * i), wd, 1'b0, lat, err, rd, width);
            checks++;
            if (lat != LATENCY + 1) begin failures++; $display("FAIL init_latency[%0d] got=%0d exp=%0d", i, lat, LATENCY + 1); end
            checks++;
            if (err !== eerr) begin failures++; $display("FAIL init_err[%0d] got=%b exp=%b", i, err, eerr); end
            checks++;
            if (width != 1) begin failures++; $display("FAIL init_pulse_width[%0d] got=%0d exp=1", i, width); end
        end
    endtask

    task automatic test_known_vectors();
        int lat, width;
        bit err, eerr;
        logic [31:0] rd;
        model(32'd2, 32'h00400010, 32'hDEADBEEF, eerr);
        do_op(32'd2, 32'h00400010, 32'hDEADBEEF, 1'b0, lat, err, rd, width);
        model(32'd1, 32'h00400010, 32'd0, eerr);
        do_op(32'd1, 32'h00400010, 32'd0, 1'b0, lat, err, rd, width);
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL vec_read_word got=%h exp=deadbeef", rd); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL vec_read_err got=%b exp=0", err); end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL vec_latency got=%0d exp=3", lat); end
        model(32'd4, 32'h00400012, 32'h0000005A, eerr);
        do_op(32'd4, 32'h00400012, 32'hFFFFFF5A, 1'b0, lat, err, rd, width);
        model(32'd1, 32'h00400010, 32'd0, eerr);
        do_op(32'd1, 32'h00400010, 32'd0, 1'b0, lat, err, rd, width);
        checks++;
        if (rd !== 32'hDE5ABEEF) begin failures++; $display("FAIL vec_byte_merge got=%h exp=de5abeef", rd); end
        model(32'd3, 32'h00400013, 32'd0, eerr);
        do_op(32'd3, 32'h00400013, 32'd0, 1'b0, lat, err, rd, width);
        checks++;
        if (rd !== 32'h000000DE) begin failures++; $display("FAIL vec_read_byte got=%h exp=000000de", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] ops   [5] = '{32'd1, 32'd1, 32'd7, 32'd2, 32'hFFFFFFFF};
        logic [31:0] addrs [5] = '{32'h00400002, 32'h003FFFFC, 32'h00400010, BASE + 32'(4 * DEPTH), 32'h00400010};
        int lat, width;
        bit err, eerr;
        logic [31:0] rd;
        for (int i = 0; i < 5; i++) begin
            model(ops[i], addrs[i], 32'hCAFEF00D, eerr);
            do_op(ops[i], addrs[i], 32'hCAFEF00D, 1'b0, lat, err, rd, width);
            checks++;
            if (err !== 1'b1 || eerr !== 1'b1 || lat != LATENCY + 1) begin
                failures++; $display("FAIL err_case[%0d] got err=%b lat=%0d exp err=1 lat=%0d", i, err, lat, LATENCY + 1);
            end
            checks++;
            if (rd !== exp_rd) begin failures++; $display("FAIL err_indata[%0d] got=%h exp=%h", i, rd, exp_rd); end
        end
        model(32'd1, 32'h00400010, 32'd0, eerr);
        do_op(32'd1, 32'h00400010, 32'd0, 1'b0, lat, err, rd, width);
        checks++;
        if (rd !== 32'hDE5ABEEF) begin failures++; $display("FAIL err_store_intact got=%h exp=de5abeef", rd); end
    endtask

    task automatic test_random(input int count, input bit scramble);
        int lat, width, sel, idx;
        bit err, eerr;
        logic [31:0] op, addr, wd, rd;
        for (int i = 0; i < count; i++) begin
            sel = $urandom_range(0, 10);
            idx = $urandom_range(0, 15);
            wd = $urandom;
            addr = BASE + 32'(4 * idx);
            case (sel)
                0, 1, 2: op = 32'd1;
                3, 4:    op = 32'd2;
                5, 6:    begin op = 32'd3; addr = addr + 32'($urandom_range(0, 3)); end
                7:       begin op = 32'd4; addr = addr + 32'($urandom_range(0, 3)); end
                8:       begin op = 32'($urandom_range(1, 2)); addr = addr + 32'($urandom_range(1, 3)); end
                9:       op = 32'($urandom_range(5, 1000));
                default: begin op = 32'($urandom_range(1, 4)); addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64)); end
            endcase
            model(op, addr, wd, eerr);
            do_op(op, addr, wd, scramble, lat, err, rd, width);
            checks++;
            if (lat != LATENCY + 1 || width != 1 || err !== eerr || rd !== exp_rd) begin
                failures++;
                $display("FAIL rand[%0d] op=%0d addr=%h got lat=%0d w=%0d err=%b rd=%h exp lat=%0d w=1 err=%b rd=%h",
                         i, op, addr, lat, width, err, rd, LATENCY + 1, eerr, exp_rd);
            end
        end
    endtask

    task automatic test_hold();
        int pulses;
        bit eerr;
        model(32'd1, 32'h00400010, 32'd0, eerr);
        memop = 32'd1;
        memaddress = 32'h00400010;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (memready) pulses++;
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL hold_single_pulse got=%0d exp=1", pulses); end
        memop = 32'd0;
        @(negedge clk);
        memop = 32'd1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (memready) pulses++;
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL hold_rearm_pulse got=%0d exp=1", pulses); end
        checks++;
        if (memindata !== exp_rd) begin failures++; $display("FAIL hold_indata got=%h exp=%h", memindata, exp_rd); end
        memop = 32'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, width, seen;
        bit err, eerr;
        logic [31:0] rd;
        // Reset during WAIT.
        memop = 32'd2;
        memaddress = 32'h00400020;
        memoutdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        seen = memready ? 1 : 0;
        rst = 1'b1;
        @(negedge clk);
        seen += memready ? 1 : 0;
        rst = 1'b0;
        exp_rd = 32'd0;
        checks++;
        if (seen != 0) begin failures++; $display("FAIL abort_wait_ready got=%0d exp=0", seen); end
        model(32'd1, 32'h00400020, 32'd0, eerr);
        do_op(32'd1, 32'h00400020, 32'd0, 1'b0, lat, err, rd, width);
        checks++;
        if (lat != LATENCY + 1) begin failures++; $display("FAIL accept_after_rst got=%0d exp=%0d", lat, LATENCY + 1); end
        checks++;
        if (rd !== exp_rd) begin failures++; $display("FAIL abort_wait_store got=%h exp=%h", rd, exp_rd); end
        // Reset during DONE.
        memop = 32'd2;
        memaddress = 32'h00400024;
        memoutdata = 32'hA5A5A5A5;
        @(posedge clk);
        seen = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            @(negedge clk);
            if (memready) seen = 1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 32'd0;
        checks++;
        if (seen != 1) begin failures++; $display("FAIL abort_done_reach got=%0d exp=1", seen); end
        model(32'd1, 32'h00400024, 32'd0, eerr);
        do_op(32'd1, 32'h00400024, 32'd0, 1'b0, lat, err, rd, width);
        checks++;
        if (rd !== exp_rd) begin failures++; $display("FAIL abort_done_store got=%h exp=%h", rd, exp_rd); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_init_words();
        test_known_vectors();
        test_errors();
        test_random(60, 1'b0);
        test_hold();
        test_reset_abort();
        test_random(40, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, backing store size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to memready (legal 1..15).
REQ-003 SHALL have parameter BASE, default 32'h00400000, byte address of word 0.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  one clock; reset is synchronous and active-high.
REQ-006 SHALL have port memop  input  32  request code from core: 0 idle, 1 read word, 2 write word, 3 read byte unsigned, 4 write byte.
REQ-007 SHALL have port memaddress  input  32  byte address of request.
REQ-008 SHALL have port memoutdata  input  32  write data from core (byte writes use bits 7:0).
REQ-009 SHALL have port memindata  output  32  read data to core.
REQ-010 SHALL have port memready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port memerror  output  1  valid with memready; request was rejected.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, DONE, REARM.
REQ-013 IDLE: memop != 0 SHALL latch memop, memaddress, memoutdata and go to WAIT with counter = LATENCY-1.
REQ-014 WAIT: counter SHALL decrement each cycle; at 0, go to DONE; inputs changing in WAIT SHALL be ignored.
REQ-015 DONE: memready SHALL be 1 for exactly this cycle; write SHALL commit in this cycle; next state REARM.
REQ-016 REARM: SHALL stay until memop == 0, then IDLE; a held nonzero memop SHALL NOT be re-executed.
REQ-017 Accept-to-memready latency SHALL equal LATENCY+1 cycles (accept edge counted as cycle 0).
REQ-018 Word index SHALL be (addr - BASE) >> 2; offset (addr - BASE) >= 4*DEPTH SHALL be an error.
REQ-019 Word ops with addr[1:0] != 0 SHALL be an error.
REQ-020 Codes 5..2^32-1 SHALL be an error.
REQ-021 On error: memerror=1 with memready, no store write, memindata unchanged.
REQ-022 Read word: memindata SHALL equal stored word at DONE.
REQ-023 Read byte: memindata SHALL equal {24'b0, byte lane addr[1:0]}, little-endian (lane 0 = bits 7:0).
REQ-024 Write byte: only lane addr[1:0] SHALL change; other three bytes preserved.
REQ-025 memindata SHALL hold its value until the next successful read completes.
REQ-026 memready and memerror SHALL be 0 outside DONE.

Reset
REQ-027 rst SHALL force state IDLE, memready=0, memerror=0, memindata=0, counter=0.
REQ-028 rst asserted in WAIT or DONE SHALL abort the request with no store write.
REQ-029 Backing store contents SHALL NOT be cleared by rst.
REQ-030 A nonzero memop present in the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-031 Package kpu_mem_pkg SHALL hold memop code constants and FSM state enum, shared with the core.
REQ-032 Backing store SHALL be sub-module mem_array: single-port synchronous RAM, 4 byte-enables, DEPTH words.
REQ-033 mem_ctrl SHALL contain FSM, latency counter, address decode, lane select, error logic only.

Verification
REQ-034 Write word 0xDEADBEEF @0x00400010, memop->0, read word same -> memindata=0xDEADBEEF, memerror=0, memready 3 cycles after accept (LATENCY=2).
REQ-035 Write byte 0x5A @0x00400012 over 0xDEADBEEF, then read word -> 0xDE5ABEEF; read byte @0x00400013 -> 0x000000DE.
REQ-036 Read word @0x00400002 and @0x003FFFFC and memop=7 -> each memerror=1 with memready, memindata unchanged, store unchanged.
REQ-037 Hold memop=1 for 10 cycles -> exactly one memready pulse; drop to 0 one cycle then 1 -> second pulse.
REQ-038 Write word 0x12345678 @0x00400020, assert rst in WAIT -> no memready; subsequent read returns prior contents.
REQ-039 Change memaddress/memoutdata during WAIT -> operation uses values latched at accept.
